ws2811_rx: RTL and testbench

- Receiver/decoder for the single-wire WS2811 serial stream that the team's ws2811 driver produces.
- Measures high-pulse widths to recover bits and assembles 24-bit pixels, reporting each with its LED index.
- Detects the latch (reset) gap as end of frame.
- Used for driver loopback self-check and as a chain-input front end on boards that consume a WS2811 stream.

---
 rtl/ws2811_rx.sv | 222 ++++++++++++++++++++++
 tb/tb_ws2811_rx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2811_rx.sv
// rtl/ws2811_rx.sv - WS2811 single-wire stream receiver: pulse-width bit recovery, 24-bit GRB pixels, latch-gap framing.
// Define WS2811_RX_FORWARD_EN to build the chain-forwarding output (dout); otherwise dout is tied low.
module ws2811_rx #(
    parameter int MIN_HIGH     = 10,
    parameter int BIT_THRESH   = 52,
    parameter int MAX_HIGH     = 110,
    parameter int RESET_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    output logic [7:0] address,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       pixel_valid,
    output logic       frame_done,
    output logic       frame_error,
    output logic       bit_error,
    output logic       dout
);

    localparam logic [15:0] MIN_W  = 16'(MIN_HIGH);
    localparam logic [15:0] BIT_W  = 16'(BIT_THRESH);
    localparam logic [15:0] MAX_W  = 16'(MAX_HIGH);
    localparam logic [15:0] GAP_W  = 16'(RESET_CYCLES);
    localparam logic [15:0] SAT_W  = 16'hFFFF;

    typedef enum logic [1:0] {
        WAIT_GAP = 2'd0,
        IDLE     = 2'd1,
        HIGH     = 2'd2,
        LOW      = 2'd3
    } state_t;

    state_t      state_q;
    logic        sync1_q;
    logic        s_din_q;
    logic        s_prev_q;
    logic [15:0] high_cnt_q;
    logic [15:0] low_cnt_q;
    logic [4:0]  bit_cnt_q;
    logic [23:0] shift_q;
    logic [7:0]  idx_q;
    logic [7:0]  address_q;
    logic [7:0]  red_q;
    logic [7:0]  green_q;
    logic [7:0]  blue_q;
    logic        pix_pend_q;
    logic        pixel_valid_q;
    logic        frame_done_q;
    logic        frame_error_q;
    logic        bit_error_q;

    logic        rise;
    logic [15:0] high_inc;
    logic [15:0] low_inc;
    logic        bit_val;
    logic [23:0] shift_d;

    // din is asynchronous: two flops to synchronize, a third for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            s_din_q  <= 1'b0;
            s_prev_q <= 1'b0;
        end else begin
            sync1_q  <= din;
            s_din_q  <= sync1_q;
            s_prev_q <= s_din_q;
        end
    end

    assign rise     = s_din_q & ~s_prev_q;
    assign high_inc = (high_cnt_q == SAT_W) ? high_cnt_q : high_cnt_q + 16'd1;
    assign low_inc  = (low_cnt_q == SAT_W) ? low_cnt_q : low_cnt_q + 16'd1;
    assign bit_val  = (high_cnt_q >= BIT_W);
    assign shift_d  = {shift_q[22:0], bit_val};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= WAIT_GAP;
            high_cnt_q    <= 16'd0;
            low_cnt_q     <= 16'd0;
            bit_cnt_q     <= 5'd0;
            shift_q       <= 24'd0;
            idx_q         <= 8'd0;
            address_q     <= 8'd0;
            red_q         <= 8'd0;
            green_q       <= 8'd0;
            blue_q        <= 8'd0;
            pix_pend_q    <= 1'b0;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            bit_error_q   <= 1'b0;
        end else begin
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            bit_error_q   <= 1'b0;
            pix_pend_q    <= 1'b0;

            // Pixel is presented the cycle after its 24th falling edge
            if (pix_pend_q) begin
                green_q       <= shift_q[23:16];
                red_q         <= shift_q[15:8];
                blue_q        <= shift_q[7:0];
                address_q     <= idx_q;
                idx_q         <= idx_q + 8'd1;
                pixel_valid_q <= 1'b1;
            end

            unique case (state_q)
                WAIT_GAP: begin
                    if (low_cnt_q == GAP_W) begin
                        state_q   <= IDLE;
                        bit_cnt_q <= 5'd0;
                        idx_q     <= 8'd0;
                        address_q <= 8'd0;
                    end else if (s_din_q) begin
                        low_cnt_q <= 16'd0;
                    end else begin
                        low_cnt_q <= low_inc;
                    end
                end

                IDLE: begin
                    if (rise) begin
                        high_cnt_q <= 16'd1;
                        state_q    <= HIGH;
                    end
                end

                HIGH: begin
                    if (s_din_q) begin
                        if (high_inc == MAX_W) begin
                            bit_error_q <= 1'b1;
                            bit_cnt_q   <= 5'd0;
                            idx_q       <= 8'd0;
                            address_q   <= 8'd0;
                            low_cnt_q   <= 16'd0;
                            state_q     <= WAIT_GAP;
                        end else begin
                            high_cnt_q <= high_inc;
                        end
                    end else if (high_cnt_q < MIN_W) begin
                        bit_error_q <= 1'b1;
                        bit_cnt_q   <= 5'd0;
                        low_cnt_q   <= 16'd1;
                        state_q     <= WAIT_GAP;
                    end else begin
                        shift_q   <= shift_d;
                        low_cnt_q <= 16'd1;
                        state_q   <= LOW;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_q  <= 5'd0;
                            pix_pend_q <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                end

                LOW: begin
                    // The gap takes priority over a coincident rising edge
                    if (low_cnt_q == GAP_W) begin
                        frame_done_q  <= 1'b1;
                        frame_error_q <= (bit_cnt_q != 5'd0);
                        bit_cnt_q     <= 5'd0;
                        idx_q         <= 8'd0;
                        address_q     <= 8'd0;
                        state_q       <= IDLE;
                    end else if (rise) begin
                        high_cnt_q <= 16'd1;
                        state_q    <= HIGH;
                    end else begin
                        low_cnt_q <= low_inc;
                    end
                end

                default: state_q <= WAIT_GAP;
            endcase
        end
    end

    assign address     = address_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign pixel_valid = pixel_valid_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;
    assign bit_error   = bit_error_q;

`ifdef WS2811_RX_FORWARD_EN
    logic fwd_want_q;
    logic fwd_en_q;

    // fwd_en_q only follows fwd_want_q while the line is low, so no forwarded pulse is ever cut
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwd_want_q <= 1'b0;
            fwd_en_q   <= 1'b0;
        end else begin
            if (frame_done_q || bit_error_q) begin
                fwd_want_q <= 1'b0;
            end else if (pixel_valid_q && (address_q == 8'd0)) begin
                fwd_want_q <= 1'b1;
            end
            if (!s_din_q) begin
                fwd_en_q <= fwd_want_q;
            end
        end
    end

    assign dout = s_din_q & fwd_en_q;
`else
    assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2811_rx.sv
// tb/tb_ws2811_rx.sv - randomized self-checking bench for ws2811_rx against a pixel-level reference model.
module tb_ws2811_rx;

    localparam int GAP = 5050;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       din = 1'b0;
    logic [7:0] address;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       pixel_valid;
    logic       frame_done;
    logic       frame_error;
    logic       bit_error;
    logic       dout;

    ws2811_rx dut (
        .clk(clk), .reset(reset), .din(din),
        .address(address), .red(red), .green(green), .blue(blue),
        .pixel_valid(pixel_valid), .frame_done(frame_done),
        .frame_error(frame_error), .bit_error(bit_error), .dout(dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] a;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        int         t;
    } pix_t;

    int   checks = 0;
    int   errors = 0;
    pix_t got_q[$];
    pix_t exp_q[$];
    int   m_idx = 0;
    int   fd_n = 0, fe_n = 0, fdfe_n = 0, be_n = 0, be_t = 0;
    int   last_fall = 0;
    int   exp_w[$], exp_r[$], dw_q[$], dr_q[$];
    int   drun = 0, dout_hi = 0;
    logic dout_prev = 1'b0;
    bit   cap = 1'b0;
    pix_t mon_p;

    always @(negedge clk) begin
        if (pixel_valid) begin
            mon_p.a = address; mon_p.r = red; mon_p.g = green; mon_p.b = blue; mon_p.t = cyc;
            got_q.push_back(mon_p);
        end
        if (frame_done) fd_n++;
        if (frame_error) fe_n++;
        if (frame_done && frame_error) fdfe_n++;
        if (bit_error) begin be_n++; be_t = cyc; end
        if (dout) dout_hi++;
        if (cap) begin
            if (dout) begin
                if (!dout_prev) begin dr_q.push_back(cyc); drun = 0; end
                drun++;
            end else if (dout_prev) begin
                dw_q.push_back(drun);
            end
        end
        dout_prev = dout;
    end

    // Reference model: pixels are numbered from 0 since the last latch gap; bytes arrive G, R, B
    task automatic model_px(input logic [23:0] grb);
        pix_t p;
        p.a = 8'(m_idx); p.g = grb[23:16]; p.r = grb[15:8]; p.b = grb[7:0]; p.t = 0;
        exp_q.push_back(p);
        m_idx = (m_idx + 1) % 256;
    endtask

    task automatic clear_obs;
        got_q.delete(); exp_q.delete();
        fd_n = 0; fe_n = 0; fdfe_n = 0; be_n = 0;
    endtask

    function automatic int hw_for(input logic b);
        return b ? int'($urandom_range(80, 56)) : int'($urandom_range(35, 12));
    endfunction

    function automatic int lw_rand();
        return int'($urandom_range(20, 10));
    endfunction

    task automatic idle(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input int hw, input int lw, input bit rec);
        din = 1'b1;
        if (rec) begin exp_w.push_back(hw); exp_r.push_back(cyc); end
        repeat (hw) @(negedge clk);
        din = 1'b0;
        last_fall = cyc;
        repeat (lw) @(negedge clk);
    endtask

    task automatic send_pixel(input logic [23:0] grb, input bit expect_it, input bit rec);
        for (int i = 23; i >= 0; i--) send_bit(hw_for(grb[i]), lw_rand(), rec);
        if (expect_it) model_px(grb);
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(hw_for(1'($urandom())), lw_rand(), 1'b0);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (address !== 8'd0) begin errors++; $display("FAIL reset_address: got %h expected 00", address); end
        checks++; if (red !== 8'd0) begin errors++; $display("FAIL reset_red: got %h expected 00", red); end
        checks++; if (green !== 8'd0) begin errors++; $display("FAIL reset_green: got %h expected 00", green); end
        checks++; if (blue !== 8'd0) begin errors++; $display("FAIL reset_blue: got %h expected 00", blue); end
        checks++; if ({pixel_valid, frame_done, frame_error, bit_error, dout} !== 5'd0) begin
            errors++; $display("FAIL reset_pulses: got %b expected 00000", {pixel_valid, frame_done, frame_error, bit_error, dout});
        end
        reset = 1'b1;
    endtask

    task automatic test_single_pixel;
        logic [23:0] grb;
        grb = 24'h003200;
        clear_obs();
        idle(6000);
        for (int i = 23; i >= 0; i--) send_bit(grb[i] ? 70 : 35, grb[i] ? 55 : 90, 1'b0);
        model_px(grb);
        idle(6000);
        m_idx = 0;
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            checks++; if ({got_q[0].a, got_q[0].r, got_q[0].g, got_q[0].b} !== {exp_q[0].a, exp_q[0].r, exp_q[0].g, exp_q[0].b}) begin
                errors++; $display("FAIL single_pixel: got a=%h r=%h g=%h b=%h expected a=%h r=%h g=%h b=%h",
                    got_q[0].a, got_q[0].r, got_q[0].g, got_q[0].b, exp_q[0].a, exp_q[0].r, exp_q[0].g, exp_q[0].b);
            end
            checks++; if (got_q[0].t - last_fall !== 4) begin errors++; $display("FAIL single_latency: got %0d expected 4", got_q[0].t - last_fall); end
        end
        checks++; if (fd_n !== 1) begin errors++; $display("FAIL single_frame_done: got %0d expected 1", fd_n); end
        checks++; if (fe_n !== 0) begin errors++; $display("FAIL single_frame_error: got %0d expected 0", fe_n); end
    endtask

    task automatic test_three_pixels;
        logic [23:0] pxs [3];
        pxs[0] = 24'hFF0000; pxs[1] = 24'h00FF00; pxs[2] = 24'h0000FF;
        clear_obs();
        for (int k = 0; k < 3; k++) send_pixel(pxs[k], 1'b1, 1'b0);
        idle(GAP);
        m_idx = 0;
        checks++; if (fd_n !== 1) begin errors++; $display("FAIL three_frame_done: got %0d expected 1", fd_n); end
        send_pixel(24'($urandom()), 1'b1, 1'b0);
        idle(GAP);
        m_idx = 0;
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL three_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if ({got_q[i].a, got_q[i].r, got_q[i].g, got_q[i].b} !== {exp_q[i].a, exp_q[i].r, exp_q[i].g, exp_q[i].b}) begin
                errors++; $display("FAIL three_pixel[%0d]: got a=%h r=%h g=%h b=%h expected a=%h r=%h g=%h b=%h", i,
                    got_q[i].a, got_q[i].r, got_q[i].g, got_q[i].b, exp_q[i].a, exp_q[i].r, exp_q[i].g, exp_q[i].b);
            end
        end
        checks++; if (fd_n !== 2 || fe_n !== 0) begin errors++; $display("FAIL three_frames: got done=%0d err=%0d expected 2/0", fd_n, fe_n); end
    endtask

    task automatic test_partial_frame;
        clear_obs();
        send_bits(12);
        idle(GAP);
        m_idx = 0;
        checks++; if (fd_n !== 1 || fe_n !== 1) begin errors++; $display("FAIL partial_flags: got done=%0d err=%0d expected 1/1", fd_n, fe_n); end
        checks++; if (fdfe_n !== 1) begin errors++; $display("FAIL partial_same_cycle: got %0d expected 1", fdfe_n); end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL partial_no_pixel: got %0d expected 0", got_q.size()); end
    endtask

    task automatic test_glitch;
        clear_obs();
        send_pixel(24'($urandom()), 1'b1, 1'b0);
        send_pixel(24'($urandom()), 1'b1, 1'b0);
        send_bits(12);
        send_bit(5, 40, 1'b0);
        checks++; if (be_n !== 1) begin errors++; $display("FAIL glitch_bit_error: got %0d expected 1", be_n); end
        checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL glitch_pixels: got %0d expected 2", got_q.size()); end
        checks++; if (address !== 8'd1) begin errors++; $display("FAIL glitch_address_hold: got %h expected 01", address); end
        idle(GAP);
        m_idx = 0;
        checks++; if (fd_n !== 0) begin errors++; $display("FAIL glitch_resync_done: got %0d expected 0", fd_n); end
        checks++; if (address !== 8'd0) begin errors++; $display("FAIL glitch_address_gap: got %h expected 00", address); end
        send_pixel(24'($urandom()), 1'b1, 1'b0);
        idle(GAP);
        m_idx = 0;
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL glitch_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if ({got_q[i].a, got_q[i].r, got_q[i].g, got_q[i].b} !== {exp_q[i].a, exp_q[i].r, exp_q[i].g, exp_q[i].b}) begin
                errors++; $display("FAIL glitch_pixel[%0d]: got a=%h r=%h g=%h b=%h expected a=%h r=%h g=%h b=%h", i,
                    got_q[i].a, got_q[i].r, got_q[i].g, got_q[i].b, exp_q[i].a, exp_q[i].r, exp_q[i].g, exp_q[i].b);
            end
        end
        checks++; if (fd_n !== 1 || fe_n !== 0) begin errors++; $display("FAIL glitch_frames: got done=%0d err=%0d expected 1/0", fd_n, fe_n); end
    endtask

    task automatic test_stuck_and_reset;
        int rise_c;
        clear_obs();
        send_pixel(24'($urandom()), 1'b1, 1'b0);
        send_pixel(24'hC35A96, 1'b1, 1'b0);
        din = 1'b1;
        rise_c = cyc;
        repeat (200) @(negedge clk);
        checks++; if (be_n !== 1) begin errors++; $display("FAIL stuck_bit_error: got %0d expected 1", be_n); end
        checks++; if (be_t - rise_c !== 112) begin errors++; $display("FAIL stuck_timing: got %0d expected 112", be_t - rise_c); end
        checks++; if (address !== 8'd0) begin errors++; $display("FAIL stuck_address: got %h expected 00", address); end
        idle(GAP);
        m_idx = 0;
        checks++; if (fd_n !== 0) begin errors++; $display("FAIL stuck_no_frame_done: got %0d expected 0", fd_n); end
        send_bits(10);
        reset = 1'b0;
        #1;
        checks++; if ({address, red, green, blue} !== 32'd0) begin
            errors++; $display("FAIL midreset_bytes: got %h expected 00000000", {address, red, green, blue});
        end
        checks++; if ({pixel_valid, frame_done, frame_error, bit_error, dout} !== 5'd0) begin
            errors++; $display("FAIL midreset_pulses: got %b expected 00000", {pixel_valid, frame_done, frame_error, bit_error, dout});
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        send_bits(14);
        send_pixel(24'($urandom()), 1'b0, 1'b0);
        idle(GAP);
        checks++; if (fd_n !== 0 || be_n !== 1) begin errors++; $display("FAIL midreset_ignored: got done=%0d biterr=%0d expected 0/1", fd_n, be_n); end
        send_pixel(24'($urandom()), 1'b1, 1'b0);
        idle(GAP);
        m_idx = 0;
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL stuck_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if ({got_q[i].a, got_q[i].r, got_q[i].g, got_q[i].b} !== {exp_q[i].a, exp_q[i].r, exp_q[i].g, exp_q[i].b}) begin
                errors++; $display("FAIL stuck_pixel[%0d]: got a=%h r=%h g=%h b=%h expected a=%h r=%h g=%h b=%h", i,
                    got_q[i].a, got_q[i].r, got_q[i].g, got_q[i].b, exp_q[i].a, exp_q[i].r, exp_q[i].g, exp_q[i].b);
            end
        end
        checks++; if (fd_n !== 1) begin errors++; $display("FAIL stuck_final_done: got %0d expected 1", fd_n); end
    endtask

    task automatic test_forward;
        clear_obs();
        exp_w.delete(); exp_r.delete(); dw_q.delete(); dr_q.delete();
        cap = 1'b1;
        send_pixel(24'($urandom()), 1'b1, 1'b0);
        send_pixel(24'($urandom()), 1'b1, 1'b1);
        idle(GAP);
        cap = 1'b0;
        m_idx = 0;
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL fwd_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if ({got_q[i].a, got_q[i].r, got_q[i].g, got_q[i].b} !== {exp_q[i].a, exp_q[i].r, exp_q[i].g, exp_q[i].b}) begin
                errors++; $display("FAIL fwd_pixel[%0d]: got a=%h r=%h g=%h b=%h expected a=%h r=%h g=%h b=%h", i,
                    got_q[i].a, got_q[i].r, got_q[i].g, got_q[i].b, exp_q[i].a, exp_q[i].r, exp_q[i].g, exp_q[i].b);
            end
        end
`ifdef WS2811_RX_FORWARD_EN
        checks++; if (dw_q.size() !== 24) begin errors++; $display("FAIL fwd_pulse_count: got %0d expected 24", dw_q.size()); end
        for (int i = 0; i < 24 && i < dw_q.size() && i < dr_q.size(); i++) begin
            checks++;
            if (dw_q[i] !== exp_w[i] || dr_q[i] - exp_r[i] !== 2) begin
                errors++; $display("FAIL fwd_pulse[%0d]: got width=%0d delay=%0d expected width=%0d delay=2", i, dw_q[i], dr_q[i] - exp_r[i], exp_w[i]);
            end
        end
        checks++; if (dout !== 1'b0) begin errors++; $display("FAIL fwd_after_gap: got %b expected 0", dout); end
`else
        checks++; if (dout_hi !== 0) begin errors++; $display("FAIL dout_const_zero: got %0d high cycles expected 0", dout_hi); end
`endif
    endtask

    initial begin
        #2;
        @(negedge clk);
        test_reset();
        test_single_pixel();
        test_three_pixels();
        test_partial_frame();
        test_glitch();
        test_stuck_and_reset();
        test_forward();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
